// File: rtl/uart_alu_pkg.sv
// Shared types for the UART-driven ALU packet controller.
// The optional ECHO opcode is enabled by UART_ALU_CTRL_ECHO_EN.
package uart_alu_pkg;

  localparam int HdrBytes     = 4;
  localparam int OperandBytes = 4;

  typedef enum logic [7:0] {
    OP_ECHO = 8'h00,
    OP_ADD  = 8'h10,
    OP_MUL  = 8'h11,
    OP_DIVU = 8'h12
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_OPND,
    S_ALU_REQ,
    S_ALU_WAIT,
    S_TX_RES,
    S_ECHO,
    S_DRAIN
  } state_e;

  function automatic logic is_alu_op(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/uart_word_serializer.sv
// Sends a 32-bit word as four bytes, least significant first.
// The word must stay stable while en_i is high.
module uart_word_serializer
  import uart_alu_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        en_i,
  input  logic [31:0] word_i,
  input  logic        tx_ready_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic        done_o
);

  logic [1:0] r_idx;
  logic       w_last;

  assign w_last  = (r_idx == 2'(OperandBytes - 1));
  assign valid_o = en_i;
  assign data_o  = en_i ? word_i[{r_idx, 3'b000} +: 8] : '0;
  assign done_o  = en_i & tx_ready_i & w_last;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_idx <= '0;
    end else if (en_i && tx_ready_i) begin
      r_idx <= w_last ? '0 : r_idx + 2'd1;
    end
  end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Packet parser bridging a UART byte stream to an external ALU.
// Define UART_ALU_CTRL_ECHO_EN to include the ECHO opcode.
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int DataWidth    = 8,
  parameter int OperandWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic [DataWidth-1:0]    rx_data_i,
  input  logic                    rx_valid_i,
  output logic                    rx_ready_o,
  output logic [DataWidth-1:0]    tx_data_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  output logic [7:0]              alu_op_o,
  output logic [OperandWidth-1:0] alu_a_o,
  output logic [OperandWidth-1:0] alu_b_o,
  output logic                    alu_valid_o,
  input  logic                    alu_ready_i,
  input  logic [OperandWidth-1:0] alu_result_i,
  input  logic                    alu_result_valid_i,
  output logic                    error_o
);

  state_e      r_state;
  state_e      w_state_nxt;
  state_e      w_hdr_nxt;
  logic [7:0]  r_op;
  logic [7:0]  r_len_lo;
  logic [1:0]  r_hcnt;
  logic [1:0]  r_bidx;
  logic [15:0] r_rem;
  logic        r_have_acc;
  logic        r_err;
  logic [31:0] r_acc;
  logic [31:0] r_opnd;
  logic [31:0] w_word;
  logic [15:0] w_len;
  logic [15:0] w_rem_hdr;
  logic        w_rx_rdy;
  logic        w_rx_fire;
  logic        w_ser_en;
  logic        w_ser_valid;
  logic        w_ser_done;
  logic [7:0]  w_ser_data;

  assign w_len     = {rx_data_i[7:0], r_len_lo};
  assign w_rem_hdr = (w_len > 16'(HdrBytes)) ? w_len - 16'(HdrBytes) : '0;
  assign w_word    = {rx_data_i[7:0], r_opnd[31:8]};
  assign w_ser_en  = (r_state == S_TX_RES);

  // Ready is gated by reset so it reads low while reset is held.
  assign rx_ready_o  = reset_ni & w_rx_rdy;
  assign w_rx_fire   = rx_valid_i & rx_ready_o;
  assign alu_valid_o = (r_state == S_ALU_REQ);
  assign alu_op_o    = r_op;
  assign alu_a_o     = r_acc;
  assign alu_b_o     = r_opnd;
  assign error_o     = r_err;

  uart_word_serializer u_ser (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .en_i       (w_ser_en),
    .word_i     (r_acc),
    .tx_ready_i (tx_ready_i),
    .data_o     (w_ser_data),
    .valid_o    (w_ser_valid),
    .done_o     (w_ser_done)
  );

  always_comb begin
    w_rx_rdy   = 1'b0;
    tx_valid_o = 1'b0;
    tx_data_o  = '0;
    unique case (r_state)
      S_IDLE, S_HDR, S_OPND: w_rx_rdy = 1'b1;
      S_DRAIN: w_rx_rdy = (r_rem != '0);
      S_TX_RES: begin
        tx_valid_o = w_ser_valid;
        tx_data_o  = w_ser_data;
      end
`ifdef UART_ALU_CTRL_ECHO_EN
      S_ECHO: begin
        w_rx_rdy   = tx_ready_i;
        tx_valid_o = rx_valid_i;
        tx_data_o  = rx_data_i;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    w_hdr_nxt = S_DRAIN;
    if (is_alu_op(r_op) &&
        w_len >= 16'(HdrBytes + OperandBytes) &&
        w_len[1:0] == 2'b00) begin
      w_hdr_nxt = S_OPND;
    end
`ifdef UART_ALU_CTRL_ECHO_EN
    if (r_op == OP_ECHO) begin
      w_hdr_nxt = (w_rem_hdr == '0) ? S_IDLE : S_ECHO;
    end
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_rx_fire) w_state_nxt = S_HDR;
      S_HDR:
        if (w_rx_fire && r_hcnt == 2'd3) w_state_nxt = w_hdr_nxt;
      S_OPND:
        if (w_rx_fire && r_bidx == 2'd3) begin
          if (r_have_acc) w_state_nxt = S_ALU_REQ;
          else if (r_rem == 16'd1) w_state_nxt = S_TX_RES;
        end
      S_ALU_REQ:
        if (alu_ready_i) w_state_nxt = S_ALU_WAIT;
      S_ALU_WAIT:
        if (alu_result_valid_i) begin
          w_state_nxt = (r_rem == '0) ? S_TX_RES : S_OPND;
        end
      S_TX_RES:
        if (w_ser_done) w_state_nxt = S_IDLE;
`ifdef UART_ALU_CTRL_ECHO_EN
      S_ECHO:
        if (w_rx_fire && r_rem == 16'd1) w_state_nxt = S_IDLE;
`endif
      S_DRAIN:
        if (r_rem == '0 || (w_rx_fire && r_rem == 16'd1)) begin
          w_state_nxt = S_IDLE;
        end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_op       <= '0;
      r_len_lo   <= '0;
      r_hcnt     <= '0;
      r_bidx     <= '0;
      r_rem      <= '0;
      r_have_acc <= 1'b0;
      r_err      <= 1'b0;
      r_acc      <= '0;
      r_opnd     <= '0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE:
          if (w_rx_fire) begin
            r_op   <= rx_data_i[7:0];
            r_hcnt <= 2'd1;
          end
        S_HDR:
          if (w_rx_fire) begin
            r_hcnt <= r_hcnt + 2'd1;
            if (r_hcnt == 2'd2) r_len_lo <= rx_data_i[7:0];
            if (r_hcnt == 2'd3) begin
              r_rem      <= w_rem_hdr;
              r_bidx     <= '0;
              r_have_acc <= 1'b0;
              r_err      <= (w_hdr_nxt == S_DRAIN);
            end
          end
        S_OPND:
          if (w_rx_fire) begin
            r_rem  <= r_rem - 16'd1;
            r_bidx <= r_bidx + 2'd1;
            r_opnd <= w_word;
            if (r_bidx == 2'd3 && !r_have_acc) begin
              r_acc      <= w_word;
              r_have_acc <= 1'b1;
            end
          end
        S_ALU_WAIT:
          if (alu_result_valid_i) r_acc <= alu_result_i;
        S_ECHO, S_DRAIN:
          if (w_rx_fire) r_rem <= r_rem - 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Scoreboard bench for uart_alu_ctrl: directed packets, queued
// expectations, and an independent monitor on tx/alu/error.
module tb_uart_alu_ctrl;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } alu_exp_t;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b1;
  logic [7:0]  rx_data_i = '0;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b1;
  logic [7:0]  alu_op_o;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic        alu_valid_o;
  logic        alu_ready_i = 1'b1;
  logic [31:0] alu_result_i = '0;
  logic        alu_result_valid_i = 1'b0;
  logic        error_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] txq[$];
  alu_exp_t   aluq[$];
  logic       errq[$];

  bit          tx_toggle = 0;
  bit          alu_hold  = 0;
  bit          pending   = 0;
  logic [31:0] pres      = '0;

  always #5 clk_i = ~clk_i;

  uart_alu_ctrl dut (
    .clk_i              (clk_i),
    .reset_ni           (reset_ni),
    .rx_data_i          (rx_data_i),
    .rx_valid_i         (rx_valid_i),
    .rx_ready_o         (rx_ready_o),
    .tx_data_o          (tx_data_o),
    .tx_valid_o         (tx_valid_o),
    .tx_ready_i         (tx_ready_i),
    .alu_op_o           (alu_op_o),
    .alu_a_o            (alu_a_o),
    .alu_b_o            (alu_b_o),
    .alu_valid_o        (alu_valid_o),
    .alu_ready_i        (alu_ready_i),
    .alu_result_i       (alu_result_i),
    .alu_result_valid_i (alu_result_valid_i),
    .error_o            (error_o)
  );

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk_i);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    n = 0;
    forever begin
      #2;
      if (rx_ready_o) break;
      n++;
      if (n > 300) begin
        n_tests++;
        n_fail++;
        $display("FAIL rx_timeout byte=%0h got=0 exp=1", b);
        break;
      end
      @(negedge clk_i);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    rx_valid_i = 1'b0;
  endtask

  task automatic put_hdr(input logic [7:0] op, input logic [15:0] len);
    send_byte(op);
    send_byte(8'hA5);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
  endtask

  task automatic put_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic exp_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) txq.push_back(w[8*i +: 8]);
  endtask

  task automatic exp_alu(input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    alu_exp_t e;
    e.op = op;
    e.a  = a;
    e.b  = b;
    aluq.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((txq.size() + aluq.size() + errq.size()) != 0 && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    chk({name, "_drained"}, 32'(txq.size() + aluq.size() + errq.size()), 0);
    repeat (4) @(negedge clk_i);
  endtask

  // Behavioural ALU: one-cycle-later response after each accepted request.
  initial begin
    forever begin
      @(negedge clk_i);
      alu_result_valid_i = 1'b0;
      if (pending) begin
        alu_result_valid_i = 1'b1;
        alu_result_i       = pres;
        pending            = 0;
      end
      alu_ready_i = !alu_hold;
      #2;
      if (reset_ni && alu_valid_o && alu_ready_i) begin
        case (alu_op_o)
          8'h10:   pres = alu_a_o + alu_b_o;
          8'h11:   pres = alu_a_o * alu_b_o;
          8'h12:   pres = (alu_b_o == 0) ? '1 : alu_a_o / alu_b_o;
          default: pres = '0;
        endcase
        pending = 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_i);
      if (tx_toggle) tx_ready_i = ~tx_ready_i;
      else           tx_ready_i = 1'b1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes an output.
  initial begin
    logic [7:0] eb;
    alu_exp_t   ea;
    forever begin
      @(negedge clk_i);
      #2;
      if (reset_ni) begin
        if (tx_valid_o && tx_ready_i) begin
          if (txq.size() == 0) begin
            chk("tx_unexpected", {24'd0, tx_data_o}, 32'hFFFF_FFFF);
          end else begin
            eb = txq.pop_front();
            chk("tx_byte", {24'd0, tx_data_o}, {24'd0, eb});
          end
        end
        if (alu_valid_o && alu_ready_i) begin
          if (aluq.size() == 0) begin
            chk("alu_unexpected", {24'd0, alu_op_o}, 32'hFFFF_FFFF);
          end else begin
            ea = aluq.pop_front();
            chk("alu_op", {24'd0, alu_op_o}, {24'd0, ea.op});
            chk("alu_a", alu_a_o, ea.a);
            chk("alu_b", alu_b_o, ea.b);
          end
        end
        if (error_o) begin
          if (errq.size() == 0) chk("err_unexpected", 1, 0);
          else chk("err_pulse", {31'd0, errq.pop_front()}, 1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset_ni = 1'b0;
    #2;
    chk("rst_rx_ready", {31'd0, rx_ready_o}, 0);
    chk("rst_tx_valid", {31'd0, tx_valid_o}, 0);
    chk("rst_alu_valid", {31'd0, alu_valid_o}, 0);
    chk("rst_error", {31'd0, error_o}, 0);
    chk("rst_alu_a", alu_a_o, 0);
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;
    #2;
    chk("rst_release_ready", {31'd0, rx_ready_o}, 1);

    // ADD 5 + 7 -> 12
    exp_alu(8'h10, 32'd5, 32'd7);
    exp_word(32'h0000_000C);
    put_hdr(8'h10, 16'd12);
    put_word(32'd5);
    put_word(32'd7);
    wait_drain("add");

    // MUL 2 * 3 * 4 -> 24
    exp_alu(8'h11, 32'd2, 32'd3);
    exp_alu(8'h11, 32'd6, 32'd4);
    exp_word(32'h0000_0018);
    put_hdr(8'h11, 16'd16);
    put_word(32'd2);
    put_word(32'd3);
    put_word(32'd4);
    wait_drain("mul");

    // DIVU 100 / 7 -> 14
    exp_alu(8'h12, 32'd100, 32'd7);
    exp_word(32'h0000_000E);
    put_hdr(8'h12, 16'd12);
    put_word(32'd100);
    put_word(32'd7);
    wait_drain("divu");

    // Single operand returns unchanged with no ALU request
    exp_word(32'hDEAD_BEEF);
    put_hdr(8'h11, 16'd8);
    put_word(32'hDEAD_BEEF);
    wait_drain("single");

    // ECHO with tx_ready toggling every cycle
    tx_toggle = 1;
`ifdef UART_ALU_CTRL_ECHO_EN
    txq.push_back(8'h41);
    txq.push_back(8'h42);
    txq.push_back(8'h43);
`else
    errq.push_back(1'b1);
`endif
    put_hdr(8'h00, 16'd7);
    send_byte(8'h41);
    send_byte(8'h42);
    send_byte(8'h43);
    wait_drain("echo");
    tx_toggle = 0;
    repeat (2) @(negedge clk_i);

    // Unknown opcode: four payload bytes drained, one error pulse
    errq.push_back(1'b1);
    put_hdr(8'h7F, 16'd8);
    put_word(32'h1122_3344);
    wait_drain("bad_op");

    // LEN not a multiple of four: five bytes drained
    errq.push_back(1'b1);
    put_hdr(8'h10, 16'd9);
    put_word(32'h5566_7788);
    send_byte(8'h99);
    wait_drain("bad_len9");

    // LEN below one ALU operand: nothing drained
    errq.push_back(1'b1);
    put_hdr(8'h10, 16'd4);
    wait_drain("bad_len4");
    #2;
    chk("after_bad_ready", {31'd0, rx_ready_o}, 1);

    // ALU stalled 20 cycles: request must hold, rx must stay closed
    alu_hold = 1;
    exp_alu(8'h10, 32'd100, 32'd200);
    exp_word(32'h0000_012C);
    put_hdr(8'h10, 16'd12);
    put_word(32'd100);
    put_word(32'd200);
    rx_data_i  = 8'hEE;
    rx_valid_i = 1'b1;
    repeat (20) begin
      @(negedge clk_i);
      #3;
      chk("stall_valid", {31'd0, alu_valid_o}, 1);
      chk("stall_a", alu_a_o, 32'd100);
      chk("stall_b", alu_b_o, 32'd200);
      chk("stall_rx_ready", {31'd0, rx_ready_o}, 0);
    end
    rx_valid_i = 1'b0;
    alu_hold   = 0;
    wait_drain("stall");

    // Reset after byte2 of an ADD packet, then a fresh packet
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h0C);
    #1 reset_ni = 1'b0;
    #2;
    chk("midrst_rx_ready", {31'd0, rx_ready_o}, 0);
    chk("midrst_alu_op", {24'd0, alu_op_o}, 0);
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;
    exp_alu(8'h10, 32'd1, 32'd2);
    exp_word(32'h0000_0003);
    put_hdr(8'h10, 16'd12);
    put_word(32'd1);
    put_word(32'd2);
    wait_drain("midrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
